// File: rtl/booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_arbiter
// Brief    : Round-robin front end that shares one booth sequential multiplier
//            between R requesters over valid/ready request/response handshakes.
//            Optional macro BOOTH_ARB_ZERO_BYPASS_EN: zero operands skip the
//            multiplier and respond with 0 one cycle after the grant.
// Revision : 1.0  initial release
// ============================================================================
module booth_arbiter #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         i_req_valid,
    input  logic [R*M-1:0]       i_req_m,
    input  logic [R*N-1:0]       i_req_n,
    output logic [R-1:0]         o_req_ready,
    output logic [R-1:0]         o_rsp_valid,
    output logic [M+N-1:0]       o_rsp_result,
    input  logic [R-1:0]         i_rsp_ready,
    output logic                 o_mul_start,
    output logic [M-1:0]         o_mul_m,
    output logic [N-1:0]         o_mul_n,
    input  logic [M+N-1:0]       i_mul_result,
    input  logic                 i_mul_end
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gnt;
    logic            r_mul_end_d;

    logic            w_any;
    logic [PW-1:0]   w_gidx;
    logic [M-1:0]    w_gm;
    logic [N-1:0]    w_gn;
    logic            w_zero;
    logic            w_end_edge;
    logic [R-1:0]    w_new_oh;
    logic [R-1:0]    w_cur_oh;

    // Scan downwards so the last hit is the closest requester at/after r_ptr.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (i_req_valid[(int'(r_ptr) + k) % R]) begin
                w_any  = 1'b1;
                w_gidx = PW'((int'(r_ptr) + k) % R);
            end
        end
    end

    assign w_gm       = i_req_m[int'(w_gidx)*M +: M];
    assign w_gn       = i_req_n[int'(w_gidx)*N +: N];
    assign w_end_edge = i_mul_end & ~r_mul_end_d;
    assign w_new_oh   = {{(R-1){1'b0}}, 1'b1} << w_gidx;
    assign w_cur_oh   = {{(R-1){1'b0}}, 1'b1} << r_gnt;

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    assign w_zero = (w_gm == '0) || (w_gn == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Ready must be combinational so the accept lands in the grant cycle itself.
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            o_req_ready = w_new_oh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_mul_end_d  <= 1'b0;
            o_rsp_valid  <= '0;
            o_rsp_result <= '0;
            o_mul_start  <= 1'b0;
            o_mul_m      <= '0;
            o_mul_n      <= '0;
        end else begin
            r_mul_end_d <= i_mul_end;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_gidx;
                        if (w_zero) begin
                            o_rsp_valid  <= w_new_oh;
                            o_rsp_result <= '0;
                            r_state      <= S_RESP;
                        end else begin
                            o_mul_m     <= w_gm;
                            o_mul_n     <= w_gn;
                            o_mul_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    o_mul_start <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // r_mul_end_d already tracked end_sig during ISSUE, so a level
                    // that rose there produces no edge here.
                    if (w_end_edge) begin
                        o_rsp_result <= i_mul_result;
                        o_rsp_valid  <= w_cur_oh;
                        o_mul_m      <= '0;
                        o_mul_n      <= '0;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready[r_gnt]) begin
                        o_rsp_valid <= '0;
                        r_ptr       <= (r_gnt == PW'(R - 1)) ? '0 : r_gnt + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_arbiter
// Brief    : Scoreboard bench for booth_arbiter with a behavioural booth stand-in.
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_arbiter;

    localparam int MUL_LAT = 6;   // cycles from start_calc to end_sig

    typedef struct {
        int          idx;
        logic [7:0]  m;
        logic [7:0]  n;
        logic [15:0] res;
        int          starts;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_m = '0;
    logic [31:0] req_n = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_ready = '0;
    logic        mul_start;
    logic [7:0]  mul_m;
    logic [7:0]  mul_n;
    logic [15:0] mul_result;
    logic        mul_end;

    exp_t        q[$];
    int          grant_log[$];
    bit   [3:0]  want = '0;
    bit   [3:0]  acc = '0;
    logic [7:0]  pm[4];
    logic [7:0]  pn[4];
    logic [15:0] pe[4];
    int          p_starts[4];
    int          p_lat[4];
    bit          auto_rdy = 1'b1;
    bit          outstanding = 1'b0;
    bit          rsp_seen = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = 0;
    int          cur_starts = 0;
    int          n_vec = 0;
    int          n_err = 0;

    booth_arbiter #(.M(8), .N(8), .R(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .i_req_m      (req_m),
        .i_req_n      (req_n),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_result (rsp_result),
        .i_rsp_ready  (rsp_ready),
        .o_mul_start  (mul_start),
        .o_mul_m      (mul_m),
        .o_mul_n      (mul_n),
        .i_mul_result (mul_result),
        .i_mul_end    (mul_end)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for booth: signed product, end_sig pulse MUL_LAT after start.
    int          mcnt;
    logic [15:0] mprod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt       <= 0;
            mprod      <= '0;
            mul_end    <= 1'b0;
            mul_result <= '0;
        end else begin
            mul_end <= 1'b0;
            if (mul_start) begin
                mcnt  <= MUL_LAT - 1;
                mprod <= 16'($signed(mul_m) * $signed(mul_n));
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mul_end    <= 1'b1;
                    mul_result <= mprod;
                end
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic post(input int i, input logic [7:0] m, input logic [7:0] n, input logic [15:0] e);
        bit byp;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
        byp = (m == 8'h00) || (n == 8'h00);
`else
        byp = 1'b0;
`endif
        pm[i]       = m;
        pn[i]       = n;
        pe[i]       = e;
        p_starts[i] = byp ? 0 : 1;
        p_lat[i]    = byp ? 1 : 2 + MUL_LAT;
        want[i]     = 1'b1;
    endtask

    // Requester side: raise posted requests, drop them the cycle after acceptance.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            req_valid = '0;
            rsp_ready = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i]       = 1'b0;
                end else if (want[i] && !req_valid[i]) begin
                    req_valid[i]     = 1'b1;
                    req_m[i*8 +: 8]  = pm[i];
                    req_n[i*8 +: 8]  = pn[i];
                    want[i]          = 1'b0;
                end
            end
            rsp_ready = auto_rdy ? 4'hF : 4'h0;
        end
    end

    // Monitor: push expectations on accept, pop and compare on response consumption.
    always @(negedge clk) begin
        exp_t e;
        int   g;
        cyc++;
        if (rst_n) begin
            if (mul_start) begin
                cur_starts++;
                if (q.size() == 0) chk("spurious_start", 32'd1, 32'd0);
                else chk("mul_operands", {mul_m, mul_n}, {q[0].m, q[0].n});
            end
            if (rsp_valid != 0 && !rsp_seen) begin
                rsp_seen = 1'b1;
                rsp_cyc  = cyc;
            end
            if ((rsp_valid & rsp_ready) != 0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (rsp_valid[i]) g = i;
                chk("rsp_onehot", $countones(rsp_valid), 1);
                if (q.size() == 0) begin
                    chk("stale_response", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_requester", g, e.idx);
                    chk("rsp_result", rsp_result, e.res);
                    chk("start_pulses", cur_starts, e.starts);
                    chk("grant_to_rsp_latency", rsp_cyc - acc_cyc, e.lat);
                end
                outstanding = 1'b0;
                rsp_seen    = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    chk("grant_while_busy", outstanding, 0);
                    q.push_back('{i, pm[i], pn[i], pe[i], p_starts[i], p_lat[i]});
                    grant_log.push_back(i);
                    acc[i]      = 1'b1;
                    outstanding = 1'b1;
                    acc_cyc     = cyc;
                    cur_starts  = 0;
                end
            end
        end
    end

    function automatic bit tb_idle();
        return (want == 0) && (req_valid == 0) && (q.size() == 0) &&
               (rsp_valid == 0) && !outstanding;
    endfunction

    task automatic wait_done(input string tag);
        int c = 0;
        do begin
            @(negedge clk); #2;
            c++;
        end while (!tb_idle() && c < 500);
        chk({"done_", tag}, tb_idle(), 1);
    endtask

    task automatic clear_bench();
        req_valid   = '0;
        rsp_ready   = '0;
        want        = '0;
        acc         = '0;
        q.delete();
        grant_log.delete();
        outstanding = 1'b0;
        rsp_seen    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        repeat (2) begin @(negedge clk); #2; end
        rst_n = 1'b1;
        @(negedge clk); #2;
    endtask

    function automatic logic [31:0] order_word();
        logic [31:0] w = 0;
        foreach (grant_log[k]) w = (w << 4) | 32'(grant_log[k]);
        return w;
    endfunction

    initial begin
        logic [3:0]  v0;
        logic [15:0] r0;
        bit          ok;
        int          c;

        repeat (3) begin @(negedge clk); #2; end
        chk("reset_outputs", {req_ready, rsp_valid, mul_start, mul_m, mul_n}, 0);
        chk("reset_result", rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk); #2;

        post(0, 8'h01, 8'h03, 16'h0003); wait_done("r0_1x3");
        post(2, 8'h7F, 8'hAD, 16'hD6D3); wait_done("r2_a");
        post(2, 8'h80, 8'h25, 16'hED80); wait_done("r2_b");
        post(2, 8'hFF, 8'hFF, 16'h0001); wait_done("r2_c");

        // All four at once, two rounds, starting from a fresh pointer.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            grant_log.delete();
            post(0, 8'h02, 8'h03, 16'h0006);
            post(1, 8'h04, 8'h05, 16'h0014);
            post(2, 8'hFE, 8'h03, 16'hFFFA);
            post(3, 8'h10, 8'h10, 16'h0100);
            wait_done("round");
            chk(r == 0 ? "rr_order_round1" : "rr_order_round2", order_word(), 32'h0123);
        end

        // Back-pressure on the response.
        do_reset();
        auto_rdy = 1'b0;
        post(1, 8'h03, 8'h07, 16'h0015);
        c = 0;
        while (rsp_valid == 0 && c < 200) begin @(negedge clk); #2; c++; end
        chk("stall_rsp_seen", rsp_valid, 4'b0010);
        post(0, 8'h06, 8'h07, 16'h002A);
        post(2, 8'h81, 8'h02, 16'hFF02);
        v0 = rsp_valid;
        r0 = rsp_result;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk); #2;
            if (rsp_valid !== v0 || rsp_result !== r0 || mul_start || req_ready != 0) ok = 1'b0;
        end
        chk("stall_stable", ok, 1);
        chk("stall_result", r0, 16'h0015);
        auto_rdy = 1'b1;
        @(negedge clk); #2;
        chk("consume_cycle_valid", rsp_valid & rsp_ready, 4'b0010);
        @(negedge clk); #2;
        chk("next_grant_after_idle", req_ready, 4'b0100);
        wait_done("stall");

        // Abort during WAIT.
        post(3, 8'h05, 8'h05, 16'h0019);
        c = 0;
        while (!mul_start && c < 200) begin @(negedge clk); #2; c++; end
        chk("abort_start_seen", mul_start, 1);
        repeat (2) begin @(negedge clk); #2; end
        rst_n = 1'b0;
        clear_bench();
        @(negedge clk); #2;
        chk("abort_outputs", {req_ready, rsp_valid, mul_start, mul_m, mul_n}, 0);
        chk("abort_result", rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk); #2;
        post(0, 8'h01, 8'h03, 16'h0003); wait_done("after_abort");
        repeat (20) begin @(negedge clk); #2; end
        chk("no_late_response", rsp_valid, 0);

        // Zero operand: bypass or normal path depending on build.
        post(1, 8'h00, 8'h55, 16'h0000); wait_done("zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
